slice_scheduler: RTL
====================

Name: slice_scheduler

Overview:
- Per-frame controller that samples the katana position once at end of frame and keeps a DEPTH-deep position history.
- Computes the signed swing vector (newest minus oldest) and its L1 speed.
- Only for fast swings, requests an angle from the shared atan2/CORDIC engine over a req/ack + result-valid handshake.
- Publishes the angle and a slice-active flag to the slicing/collision logic; sits between katana tracking and the angle engine.

Parameters:
DEPTH, 10, history length in frames (>=2); swing vector spans DEPTH-1 frames
SPEED_THRESH, 64, minimum |dx|+|dy| in pixels for a swing to count as a slice
ANGLE_W, 16, width of the signed angle word from the engine
MISS_W, 8, width of the saturating missed-result counter

Ports:
clk_in  in  1  system/pixel clock
rst_in  in  1  synchronous active-high reset
hcount_in  in  11  current pixel column
vcount_in  in  10  current pixel row
katana_x  in  11  tracked katana x, 0..1023
katana_y  in  10  tracked katana y, 0..767
katana_valid_in  in  1  tracker has a lock this frame
req_out  out  1  angle request to the shared engine
ack_in  in  1  engine accepts the request (one-cycle pulse)
dx_out  out  12  signed run sent with the request
dy_out  out  11  signed rise sent with the request
result_valid_in  in  1  engine result strobe
angle_in  in  ANGLE_W  engine result, signed
angle_out  out  ANGLE_W  last accepted angle
angle_valid_out  out  1  one-cycle pulse when angle_out updates
slice_active_out  out  1  high while the latest swing qualifies
speed_out  out  12  latest |dx|+|dy|
miss_count_out  out  MISS_W  saturating count of aborted requests

Behaviour:
- Reset is synchronous and active-high on clk_in (rst_in). On reset: state IDLE; history cleared; fill count 0; all outputs 0.
- frame_done = (hcount_in==1024 && vcount_in==768); this is true for exactly one cycle per frame.
- FSM states: IDLE, SHIFT, DELTA, REQ, WAIT.
- IDLE: on frame_done, go to SHIFT.
- SHIFT (1 cycle):
  - If katana_valid_in was high in the frame_done cycle (registered then), push (katana_x, katana_y) into history[0], shift older entries, and fill = min(fill+1, DEPTH).
  - Otherwise clear fill to 0 and deassert slice_active_out. The history contents are kept but unusable.
  - Go to DELTA.
- DELTA (1 cycle):
  - dx = history[0].x - history[DEPTH-1].x as 12-bit signed; dy = history[0].y - history[DEPTH-1].y as 11-bit signed. Operands are zero-extended before subtraction; no overflow is possible.
  - speed_out <= |dx|+|dy| (maximum 1790).
  - If fill==DEPTH and speed >= SPEED_THRESH: latch dx_out and dy_out, go to REQ.
  - Otherwise: slice_active_out <= 0, go to IDLE.
- REQ: hold req_out=1 with dx_out/dy_out stable until ack_in. On ack_in, drop req_out the next cycle and go to WAIT.
- WAIT: on result_valid_in:
  - angle_out <= angle_in; angle_valid_out pulses 1 cycle; slice_active_out <= 1.
  - Go to IDLE.
- Latency: frame_done at cycle T gives SHIFT at T+1, DELTA at T+2, req_out high from T+3. The earliest angle_valid_out is 1 cycle after result_valid_in.
- Abort: frame_done while in REQ or WAIT:
  - Drop req_out; miss_count_out increments, saturating at all-ones.
  - slice_active_out <= 0; angle_out is held.
  - Go to SHIFT, so the new frame is still sampled.
- Simultaneous frame_done and result_valid_in in WAIT: the result wins. Latch the angle and pulse angle_valid_out, with no miss counted, then go to SHIFT.
- Simultaneous frame_done and ack_in in REQ: the abort wins. The miss is counted and any later result_valid_in is ignored outside WAIT.
- result_valid_in and ack_in are ignored in every state other than WAIT and REQ respectively.
- frame_done seen in SHIFT or DELTA: cannot occur at real frame rates. If forced, it is ignored.
- Reset mid-request: req_out drops on the reset edge. Any result arriving afterwards is ignored.

Test Plan:
- Reset, then 10 frames with katana_valid_in=1 at x=100..460 step 40, y=300 constant -> first 9 frames produce no req_out. Frame 10: req_out at T+3 with dx_out=+360, dy_out=0; speed_out=360.
- Engine: ack_in 2 cycles after req, result_valid_in with angle_in=16'h0000 five cycles later -> angle_out=0, one angle_valid_out pulse, slice_active_out=1.
- Stationary katana at (512,384) for 12 frames -> speed_out=0, no req_out, slice_active_out=0.
- Diagonal swing x 900->0 step -100, y 700->160 step -60 -> dx_out=-900, dy_out=-540, speed_out=1440. Sign extension is checked on both fields.
- Engine never asserts result_valid_in -> at the next frame_done, req_out is low, miss_count_out=1. Repeat 300 frames -> saturates at 255.
- katana_valid_in=0 on frame 5 of a full history -> fill resets and slice_active_out drops. No request until 10 further valid frames.
- rst_in asserted while in WAIT, then result_valid_in -> all outputs 0, no angle_valid_out.

Source files
------------

// File: rtl/slice_scheduler.sv
// -----------------------------------------------------------------------------
// slice_scheduler
//   Per-frame swing controller between katana tracking and the shared
//   atan2/CORDIC engine. Once per frame it samples the katana position into a
//   DEPTH-deep history and forms the swing vector (newest - oldest) and its L1
//   speed. For fast swings it asks the engine for an angle over a req/ack
//   handshake and publishes the result plus a slice-active flag.
//
// Ports
//   clk_in, rst_in          clock, synchronous active-high reset
//   hcount_in, vcount_in    raster position; (1024,768) marks end of frame
//   katana_x/_y/_valid_in   tracked katana position and lock flag
//   req_out, ack_in         angle request / one-cycle engine accept
//   dx_out, dy_out          signed swing vector held stable during the request
//   result_valid_in,
//   angle_in                engine result strobe and signed angle
//   angle_out,
//   angle_valid_out         last accepted angle, one-cycle update pulse
//   slice_active_out        latest swing produced an accepted angle
//   speed_out               latest |dx|+|dy|
//   miss_count_out          saturating count of aborted requests
// -----------------------------------------------------------------------------
module slice_scheduler #(
  parameter int DEPTH        = 10,
  parameter int SPEED_THRESH = 64,
  parameter int ANGLE_W      = 16,
  parameter int MISS_W       = 8
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [10:0]               hcount_in,
  input  logic [9:0]                vcount_in,
  input  logic [10:0]               katana_x,
  input  logic [9:0]                katana_y,
  input  logic                      katana_valid_in,
  output logic                      req_out,
  input  logic                      ack_in,
  output logic signed [11:0]        dx_out,
  output logic signed [10:0]        dy_out,
  input  logic                      result_valid_in,
  input  logic signed [ANGLE_W-1:0] angle_in,
  output logic signed [ANGLE_W-1:0] angle_out,
  output logic                      angle_valid_out,
  output logic                      slice_active_out,
  output logic [11:0]               speed_out,
  output logic [MISS_W-1:0]         miss_count_out
);

  localparam int FILL_W = $clog2(DEPTH + 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SHIFT = 3'd1;
  localparam logic [2:0] ST_DELTA = 3'd2;
  localparam logic [2:0] ST_REQ   = 3'd3;
  localparam logic [2:0] ST_WAIT  = 3'd4;

  logic [2:0]                state_q, state_d;
  logic [FILL_W-1:0]         fill_q, fill_d;
  logic                      req_q, req_d;
  logic signed [11:0]        dx_q, dx_d;
  logic signed [10:0]        dy_q, dy_d;
  logic signed [ANGLE_W-1:0] angle_q, angle_d;
  logic                      angle_valid_q, angle_valid_d;
  logic                      slice_q, slice_d;
  logic [11:0]               speed_q, speed_d;
  logic [MISS_W-1:0]         miss_q, miss_d;

  // Position captured in the frame_done cycle, consumed by SHIFT.
  logic [10:0] samp_x_q;
  logic [9:0]  samp_y_q;
  logic        samp_v_q;

  logic [10:0] hist_x_q [DEPTH];
  logic [9:0]  hist_y_q [DEPTH];

  logic        frame_done;
  logic        accept_frame;
  logic [11:0] dx_w, adx_w, speed_w;
  logic [10:0] dy_w, ady_w;
  logic        qualify_w;
  logic [MISS_W-1:0] miss_inc;

  assign frame_done   = (hcount_in == 11'd1024) && (vcount_in == 10'd768);
  // A frame_done landing in SHIFT or DELTA is dropped, so only sample when
  // the FSM will actually move to SHIFT.
  assign accept_frame = frame_done &&
                        ((state_q == ST_IDLE) || (state_q == ST_REQ) || (state_q == ST_WAIT));

  // Both positions are non-negative, so a one-bit zero extension makes the
  // difference fit exactly in the signed output width.
  assign dx_w    = {1'b0, hist_x_q[0]} - {1'b0, hist_x_q[DEPTH-1]};
  assign dy_w    = {1'b0, hist_y_q[0]} - {1'b0, hist_y_q[DEPTH-1]};
  assign adx_w   = dx_w[11] ? (12'd0 - dx_w) : dx_w;
  assign ady_w   = dy_w[10] ? (11'd0 - dy_w) : dy_w;
  assign speed_w = adx_w + {1'b0, ady_w};

  assign qualify_w = (fill_q == FILL_W'(DEPTH)) && (speed_w >= 12'(SPEED_THRESH));
  assign miss_inc  = (&miss_q) ? miss_q : miss_q + MISS_W'(1);

  // NOTE: every next-state value is defaulted to its current value before the
  // case statement, so no path through this block can infer a latch.
  always_comb begin
    state_d       = state_q;
    fill_d        = fill_q;
    req_d         = req_q;
    dx_d          = dx_q;
    dy_d          = dy_q;
    angle_d       = angle_q;
    angle_valid_d = 1'b0;
    slice_d       = slice_q;
    speed_d       = speed_q;
    miss_d        = miss_q;

    case (state_q)
      ST_IDLE: begin
        if (frame_done) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (samp_v_q) begin
          fill_d = (fill_q == FILL_W'(DEPTH)) ? fill_q : fill_q + FILL_W'(1);
        end else begin
          fill_d  = '0;
          slice_d = 1'b0;
        end
        state_d = ST_DELTA;
      end
      ST_DELTA: begin
        speed_d = speed_w;
        if (qualify_w) begin
          dx_d    = dx_w;
          dy_d    = dy_w;
          req_d   = 1'b1;
          state_d = ST_REQ;
        end else begin
          slice_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        // A new frame outranks a late accept: the stale request is abandoned.
        if (frame_done) begin
          req_d   = 1'b0;
          miss_d  = miss_inc;
          slice_d = 1'b0;
          state_d = ST_SHIFT;
        end else if (ack_in) begin
          req_d   = 1'b0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A result arriving with the new frame is still used.
        if (result_valid_in) begin
          angle_d       = angle_in;
          angle_valid_d = 1'b1;
          slice_d       = 1'b1;
          state_d       = frame_done ? ST_SHIFT : ST_IDLE;
        end else if (frame_done) begin
          miss_d  = miss_inc;
          slice_d = 1'b0;
          state_d = ST_SHIFT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q       <= ST_IDLE;
      fill_q        <= '0;
      req_q         <= 1'b0;
      dx_q          <= '0;
      dy_q          <= '0;
      angle_q       <= '0;
      angle_valid_q <= 1'b0;
      slice_q       <= 1'b0;
      speed_q       <= '0;
      miss_q        <= '0;
      samp_x_q      <= '0;
      samp_y_q      <= '0;
      samp_v_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      fill_q        <= fill_d;
      req_q         <= req_d;
      dx_q          <= dx_d;
      dy_q          <= dy_d;
      angle_q       <= angle_d;
      angle_valid_q <= angle_valid_d;
      slice_q       <= slice_d;
      speed_q       <= speed_d;
      miss_q        <= miss_d;
      if (accept_frame) begin
        samp_x_q <= katana_x;
        samp_y_q <= katana_y;
        samp_v_q <= katana_valid_in;
      end
    end
  end

  // NOTE: the history array is reset because its contents reach speed_out
  // even before the history has filled; a register array this small costs
  // little to clear, unlike a RAM.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        hist_x_q[i] <= '0;
        hist_y_q[i] <= '0;
      end
    end else if ((state_q == ST_SHIFT) && samp_v_q) begin
      hist_x_q[0] <= samp_x_q;
      hist_y_q[0] <= samp_y_q;
      for (int i = 1; i < DEPTH; i++) begin
        hist_x_q[i] <= hist_x_q[i-1];
        hist_y_q[i] <= hist_y_q[i-1];
      end
    end
  end

  assign req_out          = req_q;
  assign dx_out           = dx_q;
  assign dy_out           = dy_q;
  assign angle_out        = angle_q;
  assign angle_valid_out  = angle_valid_q;
  assign slice_active_out = slice_q;
  assign speed_out        = speed_q;
  assign miss_count_out   = miss_q;

endmodule
